// File: rtl/return_stack.sv
// Registered call/return stack with full/empty status, sticky overflow/underflow flags and replace-top.
// Optional RSTACK_WRAP_EN: a push on full overwrites the oldest entry instead of being dropped.
module return_stack #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clear,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  wr_idx_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_set;
    logic              udf_set;
    logic              push_eff;
    logic              pop_eff;
    logic              replace;

    assign top_idx  = wr_idx - PTR_W'(1);
    assign empty    = (cnt == CNT_W'(0));
    assign full     = (cnt == CNT_W'(DEPTH));
    assign count    = cnt;
    assign top_data = empty ? DATA_W'(0) : mem[top_idx];

    // A pop on an empty stack is ignored when paired with a push, so that pair acts as a plain push.
    assign push_eff = push & (~pop | empty);
    assign pop_eff  = pop & ~push;
    assign replace  = push & pop & ~empty;

    // Decode the per-edge operation into storage write, pointer/count update and error events.
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = wr_idx;
        wr_idx_nxt = wr_idx;
        cnt_nxt    = cnt;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (push_eff) begin
            if (!full) begin
                wr_en      = 1'b1;
                wr_idx_nxt = wr_idx + PTR_W'(1);
                cnt_nxt    = cnt + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
`ifdef RSTACK_WRAP_EN
                wr_en      = 1'b1;
                wr_idx_nxt = wr_idx + PTR_W'(1);
`else
                wr_en      = 1'b0;
`endif
            end
        end else if (pop_eff) begin
            if (!empty) begin
                wr_idx_nxt = wr_idx - PTR_W'(1);
                cnt_nxt    = cnt - CNT_W'(1);
            end else begin
                udf_set = 1'b1;
            end
        end else if (replace) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Pointer, occupancy and sticky error flags; an error event outranks err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx    <= PTR_W'(0);
            cnt       <= CNT_W'(0);
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_idx    <= wr_idx_nxt;
            cnt       <= cnt_nxt;
            overflow  <= ovf_set | (overflow & ~err_clear);
            underflow <= udf_set | (underflow & ~err_clear);
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= push_data;
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard testbench for return_stack; a queue-based reference stack predicts every post-edge state.
module tb_return_stack;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              err_clear;
    logic [DATA_W-1:0] top_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    return_stack #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .err_clear (err_clear),
        .top_data  (top_data),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] top;
        logic [CNT_W-1:0]  cnt;
        logic              emp;
        logic              ful;
        logic              ovf;
        logic              udf;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model_q[$];
    logic              ovf_m;
    logic              udf_m;
    int                n_cmp = 0;
    int                n_err = 0;
    int                n_step = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t build_exp();
        exp_t e;
        e.top = (model_q.size() == 0) ? 8'h00 : model_q[model_q.size() - 1];
        e.cnt = CNT_W'(model_q.size());
        e.emp = (model_q.size() == 0);
        e.ful = (model_q.size() == DEPTH);
        e.ovf = ovf_m;
        e.udf = udf_m;
        return e;
    endfunction

    task automatic compare_pop(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_top"},   32'(top_data),  32'(e.top));
            check({tag, "_count"}, 32'(count),     32'(e.cnt));
            check({tag, "_empty"}, 32'(empty),     32'(e.emp));
            check({tag, "_full"},  32'(full),      32'(e.ful));
            check({tag, "_ovf"},   32'(overflow),  32'(e.ovf));
            check({tag, "_udf"},   32'(underflow), 32'(e.udf));
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        ovf_m = 1'b0;
        udf_m = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict the result, then compare after the edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d, input logic clr);
        logic set_o;
        logic set_u;
        @(negedge clk);
        push      = p;
        pop       = q;
        push_data = d;
        err_clear = clr;
        set_o = 1'b0;
        set_u = 1'b0;
        if (p && (!q || model_q.size() == 0)) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(d);
            end else begin
                set_o = 1'b1;
`ifdef RSTACK_WRAP_EN
                void'(model_q.pop_front());
                model_q.push_back(d);
`endif
            end
        end else if (q && !p) begin
            if (model_q.size() == 0) set_u = 1'b1;
            else void'(model_q.pop_back());
        end else if (p && q) begin
            model_q[model_q.size() - 1] = d;
        end
        ovf_m = set_o | (ovf_m & ~clr);
        udf_m = set_u | (udf_m & ~clr);
        exp_q.push_back(build_exp());
        @(posedge clk);
        #1;
        n_step++;
        compare_pop($sformatf("s%0d", n_step));
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = 8'h00; err_clear = 1'b0;
        model_reset();
        #12;
        exp_q.push_back(build_exp());
        compare_pop("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic push/pop ordering
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Fill, push on full, drain
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h09, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Underflow and err_clear priority
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Replace-top, and push+pop on empty
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        step(1'b1, 1'b1, 8'hBB, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hCC, 1'b0);

        // Mid-cycle asynchronous reset
        step(1'b1, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b0);
        step(1'b1, 1'b0, 8'h04, 1'b0);
        step(1'b1, 1'b0, 8'h05, 1'b0);
        step(1'b1, 1'b0, 8'h06, 1'b0);
        step(1'b1, 1'b0, 8'h07, 1'b0);
        step(1'b1, 1'b0, 8'h08, 1'b0);
        step(1'b1, 1'b0, 8'h09, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clear = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(build_exp());
        compare_pop("async_rst");
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h5A, 1'b0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
Parametrised, registered hardware call/return stack for the Harvard CPU core. Generalises the 3-bit combinational stack-pointer next-state logic into a clocked block that owns both the pointer and the storage. Adds full/empty status, sticky overflow/underflow error flags and a same-cycle push+pop (replace-top) mode. Sits beside the program counter: CALL pushes the return address, RET pops it.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2
DATA_W, 8, width of each stored return address
PTR_W, $clog2(DEPTH), width of the circular write index
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
push  input  1  push push_data this cycle
pop  input  1  pop top entry this cycle
push_data  input  DATA_W  value to push
err_clear  input  1  synchronous clear of sticky error flags
top_data  output  DATA_W  current top-of-stack; 0 when empty
count  output  CNT_W  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push refused (or oldest entry dropped) on full
underflow  output  1  sticky: pop attempted on empty

Behaviour:
- Reset (async, active-high): wr_idx=0, count=0, overflow=0, underflow=0. Storage contents are not reset. Outputs then read top_data=0, empty=1, full=0.
- State: storage mem[0..DEPTH-1]; wr_idx is the next free slot; top index is (wr_idx-1) mod DEPTH.
- top_data, empty, full and count are combinational from registered state. Zero read latency: a push at edge N is visible on top_data after edge N.
- The four cases below are evaluated per rising edge.
- push only, not full: mem[wr_idx]<=push_data; wr_idx+1 mod DEPTH; count+1.
- push only, full: see Optional Feature; overflow<=1 in both builds.
- pop only, not empty: wr_idx-1 mod DEPTH; count-1. Storage is untouched.
- pop only, empty: no state change; underflow<=1.
- push and pop, not empty: replace top. mem[top]<=push_data; wr_idx and count unchanged. No error.
- push and pop, empty: treated as push only. Pop is ignored and underflow is not set.
- Neither asserted: hold state.
- err_clear: clears overflow and underflow on the next edge. If an error event occurs in the same cycle, the set wins.
- All pointer arithmetic is modulo DEPTH via natural PTR_W wrap. count saturates at DEPTH and never wraps.
- Reset asserted mid-operation clears state immediately, regardless of clk. A push or pop coincident with reset deassertion is taken on the first edge after deassertion.

Optional Feature:
Macro RSTACK_WRAP_EN.
- Defined: a push on full is accepted circularly. mem[wr_idx]<=push_data (overwrites the oldest entry), wr_idx advances, count stays DEPTH, overflow<=1. Gives deep-recursion tolerance, losing the oldest return addresses.
- Undefined: a push on full is dropped. mem, wr_idx and count are unchanged; overflow<=1.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, top_data=0x33. Three pops -> top_data 0x22, 0x11, then 0 with empty=1. underflow stays 0.
- DEPTH=8: push 0x01..0x08 -> full=1, count=8. Push 0x09 without RSTACK_WRAP_EN -> count=8, top_data=0x08, overflow=1. Eight pops return 0x08..0x01.
- Same sequence with RSTACK_WRAP_EN -> top_data=0x09, count=8, overflow=1. Eight pops return 0x09..0x02.
- Pop on empty -> underflow=1, count=0. Assert err_clear together with a second empty pop -> underflow stays 1. err_clear alone -> underflow=0 next cycle.
- Push 0xAA, then push=pop=1 with push_data=0xBB -> count=1, top_data=0xBB. push=pop=1 while empty with 0xCC -> count=1, top_data=0xCC, underflow=0.
- Push three values, then pulse reset between clock edges -> count=0, empty=1 and flags 0 immediately, before the next edge. Next push of 0x5A -> top_data=0x5A, count=1.
